crc_stream_codec: RTL

Parametrised, handshaked successor of the 8-bit/CRC-4 serial encoder in the memory-protection path. It accepts one data word and its address per transaction and computes a CRC over the data, one bit per clock, MSB first. In encode mode it returns `{data, crc}` for storage. In check mode it recomputes the CRC over a word read back from memory and reports a syndrome and an error flag. It sits between the memory controller's write/read ports and the protected array.

---
 rtl/crc_pkg.sv | 18 +
 rtl/crc_lfsr_step.sv | 19 +
 rtl/crc_stream_codec.sv | 111 +++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC stream codec.
// Holds the FSM state encoding, mode codes and the default CRC-4 polynomial.
package crc_pkg;

    // Three-state transaction FSM: accept, shift DATA_W bits, present result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } crc_state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // x^4 + x + 1 with the implicit x^4 term dropped.
    localparam logic [3:0] CRC4_POLY = 4'h3;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit combinational next-state of a Galois (non-augmented) CRC LFSR.
// Ports: lfsr (current remainder), din (next message bit, MSB first),
//        lfsr_next (remainder after absorbing din).
module crc_lfsr_step #(
    parameter int                CRC_W = 4,
    parameter logic [CRC_W-1:0]  POLY  = 4'h3
) (
    input  logic [CRC_W-1:0] lfsr,
    input  logic             din,
    output logic [CRC_W-1:0] lfsr_next
);

    logic fb;

    // Message bit enters at the top, so no zero-padding cycles are needed.
    assign fb        = lfsr[CRC_W-1] ^ din;
    assign lfsr_next = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_stream_codec.sv
// Handshaked bit-serial CRC encoder/checker for the memory-protection path.
// Ports: clk, rst_n (async active-low); request in_valid/in_ready with mode,
//        data_in, crc_in, addr_in; result out_valid/out_ready with code_out
//        ({data, crc_calc}), addr_out, syndrome and err.
module crc_stream_codec
    import crc_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 4,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC4_POLY),
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter int               ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [CRC_W-1:0]        crc_in,
    input  logic [ADDR_W-1:0]       addr_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W+CRC_W-1:0] code_out,
    output logic [ADDR_W-1:0]       addr_out,
    output logic [CRC_W-1:0]        syndrome,
    output logic                    err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    crc_state_t        state;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] shreg;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  lfsr;
    logic [CRC_W-1:0]  lfsr_next;
    logic [ADDR_W-1:0] addr_q;
    logic              mode_q;
    logic [CNT_W-1:0]  cnt;
    logic              take;
    logic              last;
    logic              is_chk;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign take      = in_valid && in_ready;
    assign last      = (cnt == CNT_W'(DATA_W - 1));

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .lfsr      (lfsr),
        .din       (shreg[DATA_W-1]),
        .lfsr_next (lfsr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            shreg  <= '0;
            crc_q  <= '0;
            lfsr   <= '0;
            addr_q <= '0;
            mode_q <= MODE_ENC;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        data_q <= data_in;
                        shreg  <= data_in;
                        crc_q  <= crc_in;
                        addr_q <= addr_in;
                        mode_q <= mode;
                        lfsr   <= INIT;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    lfsr  <= lfsr_next;
                    shreg <= {shreg[DATA_W-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result registers only change on accept or while shifting, so the
    // outputs stay frozen for as long as DONE is back-pressured.
    assign is_chk   = (mode_q == MODE_CHK);
    assign code_out = {data_q, lfsr};
    assign addr_out = addr_q;
    assign syndrome = is_chk ? (lfsr ^ crc_q) : '0;
    assign err      = is_chk && (|syndrome);

endmodule
